load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have no parameters; types come from riscv_package (address_t, word_t, 32 bits).
REQ-002 The module SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-007 req_is_store  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal and treated as word.
REQ-009 req_unsigned  input  1  zero-extend load result (LBU/LHU).
REQ-010 req_addr  input  address_t  byte address.
REQ-011 req_wdata  input  word_t  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle completion pulse, no backpressure.
REQ-013 resp_rdata  output  word_t  extended load data (0 for stores/errors).
REQ-014 resp_error  output  1  misaligned request, valid with resp_valid.
REQ-015 mem_addr  output  address_t  word-aligned address to data memory (bits [1:0] = 0).
REQ-016 mem_write_data  output  word_t  full word to write.
REQ-017 mem_write_enable  output  1  write strobe, sampled by memory at posedge.
REQ-018 mem_read_data  input  word_t  combinational read of word at mem_addr.

Function
REQ-019 The unit SHALL use FSM states IDLE, ACCESS, WRITE, RESP.
REQ-020 IDLE: req_ready=1; when req_valid is high, the unit SHALL register size, unsigned, store, addr and wdata, then go to ACCESS (or RESP if misaligned).
REQ-021 ACCESS load: the unit SHALL capture the selected byte/half/word of mem_read_data, sign- or zero-extend it per req_unsigned, and go to RESP.
REQ-022 ACCESS word store: mem_write_enable=1 with mem_write_data=wdata, then go to RESP.
REQ-023 ACCESS sub-word store: the unit SHALL register mem_read_data with the byte/half lane at addr[1:0] replaced by wdata[7:0]/[15:0], then go to WRITE (read-modify-write).
REQ-024 WRITE: mem_write_enable=1 with the merged word, then go to RESP.
REQ-025 RESP: resp_valid=1 for exactly one cycle, then go to IDLE; req_valid presented in RESP SHALL be ignored.
REQ-026 Latency (accept at cycle N): load or word store resp_valid at N+2; sub-word store at N+3; misaligned at N+1.
REQ-027 mem_write_enable SHALL be high for exactly one cycle per store and never for loads or errors.
REQ-028 mem_addr SHALL be {addr[31:2],2'b00} of the registered address outside IDLE, and 0 in IDLE.
REQ-029 Byte lane n = addr[1:0]; half lane = addr[1]; little-endian.

Reset
REQ-030 On rst, the FSM SHALL go to IDLE with resp_valid=0, resp_rdata=0, resp_error=0, and all registers cleared.
REQ-031 mem_write_enable SHALL be gated by !rst, so a reset during ACCESS or WRITE causes no memory write and drops the request without a response.

Configuration
REQ-032 With LSU_MISALIGN_CHECK_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]≠0 SHALL skip memory access and respond with resp_error=1 and resp_rdata=0.
REQ-033 Without LSU_MISALIGN_CHECK_EN, resp_error SHALL be tied 0 and offending low address bits SHALL be cleared (half: addr[0]; word: addr[1:0]) before access.

Structure
REQ-034 The access-size encoding (mem_size_t enum: MEM_BYTE, MEM_HALF, MEM_WORD) SHALL be added to riscv_package; the FSM state enum stays local.
REQ-035 Load extraction/extension SHALL be a sub-module load_align (combinational: word, offset, size, unsigned -> result); the store merge stays inline.

Verification
REQ-036 The bench SHALL pair the unit with data_memory, which holds 0x8899AABB at 0x40.
REQ-037 LB 0x43 signed -> resp_rdata=0xFFFFFF88 at N+2, mem_write_enable never high.
REQ-038 LHU 0x42 -> resp_rdata=0x00008899 at N+2.
REQ-039 SB 0x0000005A to 0x41 -> word at 0x40 becomes 0x88995ABB, resp_valid at N+3, one write pulse in WRITE.
REQ-040 SW 0xDEADBEEF to 0x40 -> write pulse at N+1, then LW 0x40 returns 0xDEADBEEF.
REQ-041 LW 0x42: with the macro -> resp_error=1 at N+1 and no memory access; without the macro -> resp_rdata=0x8899AABB at N+2.
REQ-042 SH to 0x40 with rst asserted during WRITE -> memory unchanged, no resp_valid, req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/riscv_package.sv
// Shared RISC-V core types: address/data words and the data-memory access size.
package riscv_package;

  typedef logic [31:0] address_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  // The unused encoding 3 behaves as a full word access.
  function automatic mem_size_t decode_mem_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return MEM_BYTE;
      2'd1:    return MEM_HALF;
      default: return MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Small word-addressed data memory: combinational read, write on posedge.
module data_memory
  import riscv_package::*;
(
  input  logic     clk,
  input  address_t i_addr,
  input  word_t    i_write_data,
  input  logic     i_write_enable,
  output word_t    o_read_data
);

  word_t r_mem [0:63];

  always_ff @(posedge clk) begin
    if (i_write_enable) begin
      r_mem[i_addr[7:2]] <= i_write_data;
    end
  end

  assign o_read_data = r_mem[i_addr[7:2]];

  // Only 64 words are implemented; upper and byte-offset address bits are ignored.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_addr[31:8], i_addr[1:0]};

endmodule

// File: rtl/load_store_unit_load_align.sv
// Load alignment: picks the byte/half/word lane out of a memory word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module load_align
  import riscv_package::*;
(
  input  word_t       i_word,
  input  logic [1:0]  i_offset,
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  output word_t       o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_offset, 3'b000} +: 8];
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    case (i_size)
      MEM_BYTE: o_result = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      MEM_HALF: o_result = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default:  o_result = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding request, read-modify-write for sub-word
// stores. Define LSU_MISALIGN_CHECK_EN to report misaligned accesses as errors.
module load_store_unit
  import riscv_package::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_is_store,
  input  logic [1:0] req_size,
  input  logic       req_unsigned,
  input  address_t   req_addr,
  input  word_t      req_wdata,
  output logic       resp_valid,
  output word_t      resp_rdata,
  output logic       resp_error,
  output address_t   mem_addr,
  output word_t      mem_write_data,
  output logic       mem_write_enable,
  input  word_t      mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t    r_state;
  state_t    w_state_next;
  mem_size_t r_size;
  logic      r_unsigned;
  logic      r_store;
  address_t  r_addr;
  word_t     r_wdata;
  word_t     r_merged;
  word_t     r_rdata;

  mem_size_t w_req_size;
  address_t  w_req_addr;
  logic      w_req_error;
  logic      w_write;
  word_t     w_load_result;
  word_t     w_merged;

  assign w_req_size = decode_mem_size(req_size);

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_error;

  always_comb begin
    w_req_addr  = req_addr;
    w_req_error = ((w_req_size == MEM_HALF) && req_addr[0]) ||
                  ((w_req_size == MEM_WORD) && (req_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if ((r_state == IDLE) && req_valid) begin
      r_error <= w_req_error;
    end
  end

  assign resp_error = r_error;
`else
  // Offending low bits are dropped so the access lands on the natural boundary.
  always_comb begin
    w_req_addr  = req_addr;
    w_req_error = 1'b0;
    case (w_req_size)
      MEM_HALF: w_req_addr[0]   = 1'b0;
      MEM_WORD: w_req_addr[1:0] = 2'b00;
      default:  w_req_addr      = req_addr;
    endcase
  end

  assign resp_error = 1'b0;
`endif

  load_align u_load_align (
    .i_word     (mem_read_data),
    .i_offset   (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_result   (w_load_result)
  );

  // Sub-word store merge: replace the addressed lane(s), keep the rest of the word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       w_sel;
    logic [7:0] w_src;
    assign w_sel = ((r_size == MEM_BYTE) && (r_addr[1:0] == 2'(gi))) ||
                   ((r_size == MEM_HALF) && (r_addr[1] == 1'(gi / 2)));
    assign w_src = (r_size == MEM_HALF) ? r_wdata[8*(gi%2) +: 8] : r_wdata[7:0];
    assign w_merged[8*gi +: 8] = w_sel ? w_src : mem_read_data[8*gi +: 8];
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = w_req_error ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (r_store && (r_size != MEM_WORD)) begin
          w_state_next = WRITE;
        end else begin
          w_write      = r_store;
          w_state_next = RESP;
        end
      end
      WRITE: begin
        w_write      = 1'b1;
        w_state_next = RESP;
      end
      default: begin
        resp_valid   = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_size     <= MEM_BYTE;
      r_unsigned <= 1'b0;
      r_store    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_merged   <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_size     <= w_req_size;
            r_unsigned <= req_unsigned;
            r_store    <= req_is_store;
            r_addr     <= w_req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
          end
        end
        ACCESS: begin
          if (r_store) begin
            r_merged <= w_merged;
          end else begin
            r_rdata <= w_load_result;
          end
        end
        default: ;
      endcase
    end
  end

  // Gating with rst keeps an in-flight store from reaching memory during reset.
  assign mem_write_enable = w_write & ~rst;
  assign mem_write_data   = (r_state == WRITE) ? r_merged : r_wdata;
  assign mem_addr         = (r_state == IDLE) ? '0 : {r_addr[31:2], 2'b00};
  assign resp_rdata       = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit paired with data_memory: directed cases plus
// randomized traffic against a word-array reference model.
module tb_load_store_unit;
  import riscv_package::*;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_is_store;
  logic [1:0] req_size;
  logic       req_unsigned;
  address_t   req_addr;
  word_t      req_wdata;
  logic       resp_valid;
  word_t      resp_rdata;
  logic       resp_error;
  address_t   mem_addr;
  word_t      mem_write_data;
  logic       mem_write_enable;
  word_t      mem_read_data;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_store     (req_is_store),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  data_memory u_mem (
    .clk            (clk),
    .i_addr         (mem_addr),
    .i_write_data   (mem_write_data),
    .i_write_enable (mem_write_enable),
    .o_read_data    (mem_read_data)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] ref_mem [0:63];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off, input int sz,
                                           input bit uns);
    logic [31:0] v;
    if (sz == 0) begin
      v = (word >> (8 * off)) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input int off, input int sz,
                                            input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (sz == 2) return wd;
    sh   = (sz == 0) ? 8 * off : 16 * (off / 2);
    mask = ((sz == 0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // One request; checks latency, write pulses, response data/error, and that
  // a request shown during RESP is not taken.
  task automatic do_req(input bit st, input logic [1:0] sz_raw, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] got);
    int sz, idx, off, lat, wr, wcyc, exp_lat, exp_wcyc;
    bit mis, err, gerr;
    logic [31:0] a, exp_rdata, new_word;
    sz  = (sz_raw == 2'd3) ? 2 : int'(sz_raw);
    mis = ((sz == 1) && addr[0]) || ((sz == 2) && (addr[1:0] != 2'b00));
    err = CHK_EN && mis;
    a   = addr;
    if (!CHK_EN && sz == 1) a[0] = 1'b0;
    if (!CHK_EN && sz == 2) a[1:0] = 2'b00;
    idx       = int'(a[7:2]);
    off       = int'(a[1:0]);
    new_word  = ref_store(ref_mem[idx], off, sz, wd);
    exp_lat   = err ? 1 : ((st && sz != 2) ? 3 : 2);
    exp_wcyc  = (st && !err) ? ((sz == 2) ? 1 : 2) : 0;
    exp_rdata = (st || err) ? 32'h0 : ref_load(ref_mem[idx], off, sz, uns);

    @(negedge clk);
    check_eq("req_ready", req_ready, 1);
    req_is_store = st; req_size = sz_raw; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0; wr = 0; wcyc = 0; got = 32'h0; gerr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_write_enable) begin
        wr++;
        wcyc = k;
        check_eq("wr_addr", mem_addr, {a[31:2], 2'b00});
        check_eq("wr_data", mem_write_data, new_word);
      end
      if (resp_valid) begin
        lat  = k;
        got  = resp_rdata;
        gerr = resp_error;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("latency", lat, exp_lat);
    check_eq("rdata", got, exp_rdata);
    check_eq("error", gerr, err);
    check_eq("wr_count", wr, (st && !err) ? 1 : 0);
    check_eq("wr_cycle", wcyc, exp_wcyc);

    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd2; req_addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("resp_pulse", resp_valid, 0);
    check_eq("resp_ignore", req_ready, 1);

    if (st && !err) ref_mem[idx] = new_word;
    $display("txn %s sz=%0d uns=%0d addr=0x%02h wd=0x%08h -> rdata=0x%08h err=%0d lat=%0d wr=%0d",
             st ? "ST" : "LD", sz_raw, uns, addr, wd, got, gerr, lat, wr);
  endtask

  initial begin
    logic [31:0] got;
    int bad_resp, bad_wr;
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_rdata", resp_rdata, 0);
    check_eq("rst_resp_error", resp_error, 0);
    check_eq("rst_mem_we", mem_write_enable, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_req_ready", req_ready, 1);

    for (int i = 16; i < 24; i++) begin
      do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), (i == 16) ? 32'h8899AABB : $urandom, got);
    end

    do_req(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, got);
    check_eq("LB_0x43", got, 32'hFFFFFF88);
    do_req(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, got);
    check_eq("LHU_0x42", got, 32'h00008899);
    do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, got);
    check_eq("LW_0x42", got, CHK_EN ? 32'h0 : 32'h8899AABB);
    do_req(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000005A, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got);
    check_eq("SB_merge", got, 32'h88995ABB);
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got);
    check_eq("SW_readback", got, 32'hDEADBEEF);

    // SH interrupted by reset while in WRITE: memory must stay untouched.
    @(negedge clk);
    req_is_store = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h00001234; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("sh_we_in_write", mem_write_enable, 1);
    rst = 1'b1;
    #1;
    check_eq("sh_we_gated", mem_write_enable, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("sh_rst_resp", resp_valid, 0);
    check_eq("sh_rst_ready", req_ready, 1);
    bad_resp = 0; bad_wr = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) bad_resp++;
      if (mem_write_enable) bad_wr++;
      @(posedge clk); #1;
    end
    check_eq("sh_rst_no_resp", bad_resp, 0);
    check_eq("sh_rst_no_write", bad_wr, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got);
    check_eq("sh_rst_mem", got, 32'hDEADBEEF);

    for (int i = 0; i < 80; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'h40 + 32'($urandom_range(0, 31)), $urandom, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
